// File: rtl/pd_rx_dec.sv
// pd_rx_dec: reassembles 4-beat descriptor groups into one decoded record; consistency checks under PD_RX_CHK_EN.
// Latency: the record is visible on the output one cycle after its B3 beat is accepted.
// Backpressure: in_pd_rdy drops while the record FIFO is full, stalling any beat of a group.
module pd_rx_dec #(
    parameter int PDWID    = 128,
    parameter int FIFO_DEP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_pd_vld,
    output logic             in_pd_rdy,
    input  logic [PDWID-1:0] in_pd_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [3:0]       out_fwd,
    output logic [7:0]       out_ptyp,
    output logic [15:0]      out_fid,
    output logic [11:0]      out_pptr,
    output logic [15:0]      out_plen,
    output logic [15:0]      out_cks,
    output logic [3:0]       out_oport,
    output logic [31:0]      out_seqn,
    output logic [31:0]      out_ackn,
    output logic             out_err,
    output logic [15:0]      stat_grp,
    output logic [15:0]      stat_err
);
    localparam int AW = (FIFO_DEP > 1) ? $clog2(FIFO_DEP) : 1;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    typedef enum logic [1:0] {B0, B1, B2, B3} bcnt_e;

    typedef struct packed {
        logic [3:0]  fwd;
        logic [7:0]  ptyp;
        logic [15:0] fid;
        logic [11:0] pptr;
        logic [15:0] plen;
        logic [15:0] cks;
        logic [3:0]  oport;
        logic [31:0] seqn;
        logic [31:0] ackn;
        logic        err;
    } rec_t;

    bcnt_e         bcnt_q, bcnt_d;
    logic [127:16] hdr_q, hdr_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0]   grp_q, grp_d;
    rec_t          mem_q [FIFO_DEP];
    rec_t          mem_d [FIFO_DEP];
    rec_t          wr_rec, head;
    logic          full, empty, beat_acc, push, pop;
    logic          unused_bits;

`ifdef PD_RX_CHK_EN
    logic [79:16]  sa_q, sa_d;
    logic          err_q, err_d;
    logic [15:0]   serr_q, serr_d;
    logic          beat_err;
`endif

    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign in_pd_rdy = !full;
    assign beat_acc  = in_pd_vld && in_pd_rdy;
    assign push      = beat_acc && (bcnt_q == B3);
    assign pop       = !empty && out_rdy;

`ifdef PD_RX_CHK_EN
    // Seq/ack beats must repeat the header's upper bits, carry a zero tail and match each other.
    always_comb begin
        beat_err = 1'b0;
        if (bcnt_q != B0) begin
            if (in_pd_dat[127:80] != hdr_q[127:80]) beat_err = 1'b1;
            if (in_pd_dat[15:0] != 16'h0)           beat_err = 1'b1;
            if ((bcnt_q != B1) && (in_pd_dat[79:16] != sa_q)) beat_err = 1'b1;
        end
    end
    assign unused_bits = ^{hdr_q[63:44], hdr_q[23:16]};
`else
    assign unused_bits = ^{hdr_q[63:44], hdr_q[23:16], hdr_q[115:112], hdr_q[95:92], in_pd_dat[15:0]};
`endif

    always_comb begin
        wr_rec       = '0;
        wr_rec.fwd   = hdr_q[127:124];
        wr_rec.ptyp  = hdr_q[123:116];
        wr_rec.fid   = hdr_q[111:96];
        wr_rec.pptr  = hdr_q[91:80];
        wr_rec.plen  = hdr_q[79:64];
        wr_rec.cks   = hdr_q[43:28];
        wr_rec.oport = hdr_q[27:24];
        wr_rec.seqn  = in_pd_dat[79:48];
        wr_rec.ackn  = in_pd_dat[47:16];
`ifdef PD_RX_CHK_EN
        wr_rec.err   = err_q | beat_err;
`endif
    end

    always_comb begin
        bcnt_d   = bcnt_q;
        hdr_d    = hdr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        grp_d    = grp_q;
        mem_d    = mem_q;
        if (beat_acc) begin
            bcnt_d = bcnt_e'(bcnt_q + 2'd1);
            if (bcnt_q == B0) hdr_d = in_pd_dat[127:16];
        end
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_rec;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            grp_d    = grp_q + 16'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

`ifdef PD_RX_CHK_EN
    always_comb begin
        sa_d   = sa_q;
        err_d  = err_q;
        serr_d = serr_q;
        if (beat_acc) begin
            if (bcnt_q == B0) begin
                err_d = 1'b0;
            end else begin
                sa_d  = in_pd_dat[79:16];
                err_d = err_q | beat_err;
            end
        end
        if (push && wr_rec.err) serr_d = serr_q + 16'd1;
    end
`endif

    // First-word fall-through: the head entry drives the outputs, zeroed while empty.
    always_comb begin
        head = '0;
        if (!empty) head = mem_q[rd_ptr_q[AW-1:0]];
    end

    assign out_vld   = !empty;
    assign out_fwd   = head.fwd;
    assign out_ptyp  = head.ptyp;
    assign out_fid   = head.fid;
    assign out_pptr  = head.pptr;
    assign out_plen  = head.plen;
    assign out_cks   = head.cks;
    assign out_oport = head.oport;
    assign out_seqn  = head.seqn;
    assign out_ackn  = head.ackn;
    assign out_err   = head.err;
    assign stat_grp  = grp_q;
`ifdef PD_RX_CHK_EN
    assign stat_err  = serr_q;
`else
    assign stat_err  = 16'h0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q   <= B0;
            hdr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            grp_q    <= '0;
            for (int i = 0; i < FIFO_DEP; i++) mem_q[i] <= '0;
`ifdef PD_RX_CHK_EN
            sa_q     <= '0;
            err_q    <= 1'b0;
            serr_q   <= '0;
`endif
        end else begin
            bcnt_q   <= bcnt_d;
            hdr_q    <= hdr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            grp_q    <= grp_d;
            mem_q    <= mem_d;
`ifdef PD_RX_CHK_EN
            sa_q     <= sa_d;
            err_q    <= err_d;
            serr_q   <= serr_d;
`endif
        end
    end
endmodule
